// File: rtl/mc_column_sequencer.sv
// -----------------------------------------------------------------------------
// mc_column_sequencer
//
// Purpose:
//   Time-multiplexes one shared 32-bit (Inv)MixColumns column datapath over a
//   128-bit AES state. A state is accepted on a valid/ready input port, its four
//   columns are presented to the external datapath one per cycle (column 0
//   first), the returned columns are collected, and the complete state is
//   offered on a valid/ready output port. This block does no GF(2^8) math.
//
// Parameters:
//   DP_LAT  datapath latency: 0 = combinational return, 1 = registered return
//   NCOL    columns per state; only 4 is legal
//
// Configuration macro:
//   INVMC_SEQ_EN  defined   : in_inv is latched at accept and drives dp_inv
//                 undefined : in_inv is ignored and dp_inv is tied low
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    input state valid
//   in_ready   out  1    sequencer can accept a state (IDLE only)
//   in_state   in   128  state; column i = in_state[127-32*i -: 32]
//   in_inv     in   1    1 = InvMixColumns, sampled at accept
//   in_skip    in   1    1 = bypass, state returned unmodified
//   dp_col     out  32   column presented to the datapath {a0,a1,a2,a3}
//   dp_inv     out  1    direction select to the datapath
//   dp_res     in   32   datapath result {b0,b1,b2,b3}
//   out_valid  out  1    result state valid
//   out_ready  in   1    consumer accepts result
//   out_state  out  128  result state, same ordering as in_state
//   busy       out  1    high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mc_column_sequencer #(
   parameter int DP_LAT = 0,
   parameter int NCOL   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_inv,
   input  logic         in_skip,
   output logic [31:0]  dp_col,
   output logic         dp_inv,
   input  logic [31:0]  dp_res,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   // Configuration sanity: the column walk below is hard-wired for 4 columns
   // and a datapath latency of 0 or 1.
   generate
      if (NCOL != 4) begin : g_ncol_err
         $error("mc_column_sequencer: NCOL must be 4");
      end
      if (DP_LAT != 0 && DP_LAT != 1) begin : g_lat_err
         $error("mc_column_sequencer: DP_LAT must be 0 or 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state_reg;
   logic [1:0]    col_cnt_reg;
   logic [31:0]   src_reg [4];     // columns of the accepted state
   logic [31:0]   res_reg [4];     // columns returned by the datapath
   logic          in_ready_reg;
   logic          out_valid_reg;
   logic          busy_reg;
   logic [31:0]   dp_col_reg;
   logic          dp_inv_reg;
   logic [127:0]  out_state_reg;

   // Column view of the incoming state, column 0 in the top 32 bits.
   logic [31:0]   in_col [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_in_col
         assign in_col[gi] = in_state[127-32*gi -: 32];
      end
   endgenerate

   // Capture strobe and target column for the datapath return.
   // With a registered datapath the result trails dp_col by one cycle, so the
   // first ISSUE cycle has nothing to capture and DRAIN picks up column 3.
   // col_cnt stays at 3 through DRAIN, which is exactly the column captured.
   logic          wr_en;
   logic [1:0]    wr_idx;

   always_comb begin
      wr_en  = 1'b0;
      wr_idx = col_cnt_reg;
      if (DP_LAT == 0) begin
         wr_en  = (state_reg == ISSUE);
         wr_idx = col_cnt_reg;
      end else begin
         wr_en  = ((state_reg == ISSUE) && (col_cnt_reg != 2'd0)) ||
                  (state_reg == DRAIN);
         wr_idx = (state_reg == DRAIN) ? col_cnt_reg : col_cnt_reg - 2'd1;
      end
   end

   // The final capture is always column 3; columns 0..2 are already in res_reg.
   logic [127:0]  final_state;
   assign final_state = {res_reg[0], res_reg[1], res_reg[2], dp_res};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         col_cnt_reg   <= 2'd0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         dp_col_reg    <= 32'd0;
         dp_inv_reg    <= 1'b0;
         out_state_reg <= 128'd0;
      end else begin
         if (wr_en) begin
            res_reg[wr_idx] <= dp_res;
         end

         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < 4; i++) begin
                     src_reg[i] <= in_col[i];
                  end
`ifdef INVMC_SEQ_EN
                  dp_inv_reg <= in_inv;
`endif
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  if (in_skip) begin
                     state_reg     <= DONE;
                     out_state_reg <= in_state;
                     out_valid_reg <= 1'b1;
                  end else begin
                     state_reg   <= ISSUE;
                     col_cnt_reg <= 2'd0;
                     // Pre-load column 0 so it is on dp_col during the
                     // first ISSUE cycle.
                     dp_col_reg  <= in_col[0];
                  end
               end
            end

            ISSUE: begin
               if (col_cnt_reg == 2'd3) begin
                  // dp_col and col_cnt hold their last values from here on.
                  if (DP_LAT == 0) begin
                     state_reg     <= DONE;
                     out_state_reg <= final_state;
                     out_valid_reg <= 1'b1;
                  end else begin
                     state_reg <= DRAIN;
                  end
               end else begin
                  col_cnt_reg <= col_cnt_reg + 2'd1;
                  dp_col_reg  <= src_reg[col_cnt_reg + 2'd1];
               end
            end

            DRAIN: begin
               state_reg     <= DONE;
               out_state_reg <= final_state;
               out_valid_reg <= 1'b1;
            end

            DONE: begin
               // No same-cycle re-accept: IDLE must be visited first.
               if (out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  busy_reg      <= 1'b0;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

`ifndef INVMC_SEQ_EN
   // Forward-only build: direction input is not used.
   logic unused_in_inv;
   assign unused_in_inv = in_inv;
`endif

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign busy      = busy_reg;
   assign dp_col    = dp_col_reg;
   assign dp_inv    = dp_inv_reg;
   assign out_state = out_state_reg;

endmodule
